mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined ARM core.
- Replaces the separate imem/dmem pair. Each requester holds its request until it sees a one-cycle ready pulse; the pipeline stalls on the missing ready.
- Data has priority over fetch when both request from idle.
- Also keeps a saturating fetch-wait counter for performance debug.

Parameters:
- LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- CW, 16, width of the fetch-wait performance counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch read data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  memory address, latched at grant
- mem_wdata  out  32  memory write data, latched at grant
- mem_rdata  in  32  memory read data, valid LAT cycles after mem_en
- fetch_wait  out  CW  saturating count of cycles with if_req=1 and fetch not owning the memory

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. A 4-bit down-counter cnt is active in the BUSY states.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - mem_en, mem_we, if_ready, d_ready = 0.
  - mem_addr, mem_wdata = 0; fetch_wait = 0.
  - An in-flight access is abandoned: no ready pulse is issued after reset is released.
- IDLE:
  - At a clock edge, d_req=1 grants data → BUSY_D. Otherwise if_req=1 grants fetch → BUSY_I. Otherwise remain in IDLE.
  - At grant, latch mem_addr, mem_we and mem_wdata from the winner. Fetch: mem_we=0, mem_wdata unchanged. Set cnt=LAT.
- Access timing (grant edge at end of cycle T-1):
  - mem_en=1 in cycle T only.
  - Completion cycle is T+LAT: cnt reaches 0, the owner's ready=1, and x_rdata=mem_rdata (combinational pass-through).
  - Stores use identical timing; d_rdata is don't-care on a store.
  - Address/data changes from the requester after grant are ignored.
- Completion edge (end of cycle T+LAT):
  - Re-arbitrate, excluding the completing requester (its req is still high in that cycle).
  - If the other requester is requesting, grant it directly: the next cycle is its mem_en cycle, with no IDLE bubble. Otherwise go to IDLE.
  - Back-to-back service of the same requester always passes through one IDLE cycle. Strict alternation under continuous contention follows from this.
- Only the owner's ready may pulse; if_ready and d_ready are never both 1.
- x_rdata when not ready: drives mem_rdata, no meaning.
- Requests deasserting mid-access (protocol violation): the access still completes and ready still pulses.
- fetch_wait:
  - Increments on each clock where if_req=1 and state is not BUSY_I.
  - Saturates at 2^CW-1.
  - Cleared only by reset.
- Requester-side latency: best case LAT+2 cycles from req assertion to ready (grant edge plus LAT+1 BUSY cycles).

Test Plan:
- Reset release, LAT=2, if_req=1, if_addr=0x00000010 → mem_en one cycle after grant with mem_addr=0x10, mem_we=0; if_ready=1 two cycles later with if_rdata=mem_rdata; total 4 cycles from req.
- if_req and d_req rise together (d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF) → data granted first (mem_we=1, mem_wdata=0xDEADBEEF); fetch mem_en in the cycle right after d_ready, with no bubble; fetch_wait=4 at if_ready.
- Both requesters held high for 20 cycles → grants alternate D,I,D,I; mem_en period exactly LAT+1=3 cycles; ready never simultaneous.
- Fetch alone issues 3 back-to-back requests → an IDLE cycle between each, mem_en period 4 cycles; fetch_wait increments only during IDLE/grant cycles.
- reset driven low in the cycle after mem_en of a data load → all outputs 0 immediately; no d_ready after release; a fresh request is serviced normally.
- CW=4, fetch blocked by 6 consecutive data accesses → fetch_wait saturates at 15 and holds.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data wins from idle; a completing owner hands over directly to a waiting peer.
`default_nettype none

module mem_arbiter #(
    parameter int LAT = 2,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [CW-1:0] fetch_wait
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0]    LAT_CNT = 4'(LAT);
    localparam logic [CW-1:0] FW_MAX  = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       done;
    logic       grant_i;
    logic       grant_d;

    assign done = (cnt == 4'd0);

    // The completing owner is excluded from re-arbitration so a waiting peer
    // is granted without an idle bubble.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req)
                    grant_d = 1'b1;
                else if (if_req)
                    grant_i = 1'b1;
            end
            BUSY_I: begin
                if (done) begin
                    if (d_req)
                        grant_d = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (done) begin
                    if (if_req)
                        grant_i = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_d)
            state_nxt = BUSY_D;
        else if (grant_i)
            state_nxt = BUSY_I;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_en <= grant_i | grant_d;
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
                cnt       <= LAT_CNT;
            end else if (grant_i) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
                cnt      <= LAT_CNT;
            end else if (!done) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fetch_wait <= '0;
        else if (if_req && (state != BUSY_I) && (fetch_wait != FW_MAX))
            fetch_wait <= fetch_wait + 1'b1;
    end

    assign if_ready = (state == BUSY_I) && done;
    assign d_ready  = (state == BUSY_D) && done;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based scoreboard for grants and read data.
`default_nettype none

module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] fetch_wait;

    mem_arbiter #(.LAT(LAT), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fetch_wait (fetch_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Memory model: stores land at the mem_en edge, loads appear LAT cycles after mem_en.
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] pd [LAT];
    logic        pv [LAT];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (mem_store.exists(a))
            return mem_store[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    initial for (int i = 0; i < LAT; i++) pv[i] = 1'b0;

    always @(posedge clk) begin
        if (mem_en && mem_we)
            mem_store[mem_addr] = mem_wdata;
        pv[0] <= mem_en && !mem_we;
        pd[0] <= mem_model(mem_addr);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0BAD0;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    grant_t      grant_q [$];
    logic [31:0] if_q [$];
    logic [32:0] d_q [$];
    int          en_cyc [$];
    int          rdy_if_cyc = 0;
    int          rdy_d_cyc  = 0;
    int          d_rdy_cnt  = 0;
    logic [31:0] fw_at_if   = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (if_ready || d_ready)
                chk("ready_exclusive", 32'(if_ready & d_ready), 32'd0);
            if (mem_en) begin
                en_cyc.push_back(cyc);
                if (grant_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: actual addr=0x%08h required=no grant", mem_addr);
                end else begin
                    grant_t g;
                    g = grant_q.pop_front();
                    chk(g.is_d ? "d_mem_addr" : "if_mem_addr", mem_addr, g.addr);
                    chk(g.is_d ? "d_mem_we" : "if_mem_we", 32'(mem_we), 32'(g.we));
                    if (g.we)
                        chk("d_mem_wdata", mem_wdata, g.wdata);
                end
            end
            if (if_ready) begin
                rdy_if_cyc = cyc;
                fw_at_if   = 32'(fetch_wait);
                if (if_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_if_ready: actual=1 required=0");
                end else begin
                    chk("if_rdata", if_rdata, if_q.pop_front());
                end
            end
            if (d_ready) begin
                rdy_d_cyc = cyc;
                d_rdy_cnt++;
                if (d_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_d_ready: actual=1 required=0");
                end else begin
                    logic [32:0] e;
                    e = d_q.pop_front();
                    if (e[32])
                        chk("d_rdata", d_rdata, e[31:0]);
                end
            end
        end
    end

    task automatic exp_fetch(input logic [31:0] a);
        grant_q.push_back('{is_d: 1'b0, we: 1'b0, addr: a, wdata: 32'd0});
        if_q.push_back(mem_model(a));
    endtask

    task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd);
        grant_q.push_back('{is_d: 1'b1, we: we, addr: a, wdata: wd});
        d_q.push_back({!we, rd});
    endtask

    // Callers sit just after a rising edge; returns just after the completion edge.
    task automatic wait_ready(input bit is_d, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = is_d ? d_ready : if_ready;
        end
        chk(name, 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic req_fetch(input logic [31:0] a, input bit keep);
        if_req  = 1'b1;
        if_addr = a;
        wait_ready(1'b0, "if_ready_seen");
        if (!keep) if_req = 1'b0;
    endtask

    task automatic req_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input bit keep);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        wait_ready(1'b1, "d_ready_seen");
        if (!keep) d_req = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        en_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int req_cyc;

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        #2 reset = 1'b0;

        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_fetch_wait", 32'(fetch_wait), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single fetch: mem_en one cycle after request, ready LAT+1 cycles after request.
        en_cyc.delete();
        exp_fetch(32'h10);
        req_cyc = cyc;
        req_fetch(32'h10, 1'b0);
        chk("t1_latency", 32'(rdy_if_cyc - req_cyc), 32'(LAT + 1));
        chk("t1_en_delay", 32'(en_cyc.size() > 0 ? en_cyc[0] - req_cyc : -1), 32'd1);

        // Simultaneous requests: store first, fetch handed over with no bubble.
        do_reset();
        exp_data(1'b1, 32'h80, 32'hDEADBEEF, 32'd0);
        exp_fetch(32'h20);
        fork
            req_data(1'b1, 32'h80, 32'hDEADBEEF, 1'b0);
            req_fetch(32'h20, 1'b0);
        join
        chk("t2_no_bubble", 32'(en_cyc.size() > 1 ? en_cyc[1] - rdy_d_cyc : -1), 32'd1);
        chk("t2_fetch_wait", fw_at_if, 32'd4);

        // Continuous contention: strict D/I alternation, saturating fetch_wait.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            exp_data(1'b0, 32'h100 + 32'(k * 4), 32'd0, mem_model(32'h100 + 32'(k * 4)));
            exp_fetch(32'h200 + 32'(k * 4));
        end
        fork
            begin
                for (int k = 0; k < 6; k++)
                    req_data(1'b0, 32'h100 + 32'(k * 4), 32'd0, k < 5);
            end
            begin
                for (int k = 0; k < 6; k++)
                    req_fetch(32'h200 + 32'(k * 4), k < 5);
            end
        join
        chk("t3_grant_count", 32'(en_cyc.size()), 32'd12);
        for (int i = 0; i + 1 < en_cyc.size(); i++)
            chk("t3_en_period", 32'(en_cyc[i+1] - en_cyc[i]), 32'(LAT + 1));
        chk("t3_fw_sat_at_ready", fw_at_if, 32'd15);
        repeat (3) @(posedge clk);
        #1 chk("t3_fw_hold", 32'(fetch_wait), 32'd15);

        // Back-to-back fetches: one idle cycle between accesses.
        do_reset();
        for (int k = 0; k < 3; k++)
            exp_fetch(32'h300 + 32'(k * 4));
        for (int k = 0; k < 3; k++)
            req_fetch(32'h300 + 32'(k * 4), k < 2);
        chk("t4_grant_count", 32'(en_cyc.size()), 32'd3);
        for (int i = 0; i + 1 < en_cyc.size(); i++)
            chk("t4_en_period", 32'(en_cyc[i+1] - en_cyc[i]), 32'(LAT + 2));
        chk("t4_fetch_wait", 32'(fetch_wait), 32'd3);

        // Reset in the cycle after mem_en of a load abandons it.
        do_reset();
        grant_q.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'd0});
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        d_req     = 1'b0;
        d_rdy_cnt = 0;
        #1;
        chk("t5_grant_seen", 32'(grant_q.size()), 32'd0);
        chk("t5_mem_en", 32'(mem_en), 32'd0);
        chk("t5_d_ready", 32'(d_ready), 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("t5_no_d_ready", 32'(d_rdy_cnt), 32'd0);
        exp_data(1'b0, 32'h80, 32'd0, 32'hDEADBEEF);
        req_data(1'b0, 32'h80, 32'd0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("end_grant_q", 32'(grant_q.size()), 32'd0);
        chk("end_if_q", 32'(if_q.size()), 32'd0);
        chk("end_d_q", 32'(d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
